// File: rtl/mx_pkg.sv
// Shared 4x4 matrix definitions for the inverse and multiply stages.
// Row-major element addressing, sequencer state encoding.
package mx_pkg;
    localparam int MX_N  = 4;
    localparam int MX_AW = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mx_state_t;

    function automatic logic [MX_AW-1:0] mx_addr(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return {row, col};
    endfunction
endpackage

// File: rtl/mult_axbinv_ctrl_if.sv
// Register-file and control bundle for the MxC = MxA * MxBinv stage.
// master: the sequencer; slave: the register files and upstream control.
interface mult_axbinv_ctrl_if #(
    parameter int DW   = 8,
    parameter int ACCW = 2*DW+2
);
    logic                        start;
    logic [mx_pkg::MX_AW-1:0]    addrMxA;
    logic [mx_pkg::MX_AW-1:0]    addrMxBinv;
    logic                        reMx;
    logic signed [DW-1:0]        dataA;
    logic signed [DW-1:0]        dataBinv;
    logic [mx_pkg::MX_AW-1:0]    addrMxC;
    logic                        weMxC;
    logic signed [ACCW-1:0]      dataC;
    logic                        busy;
    logic                        done;

    modport master (
        input  start, dataA, dataBinv,
        output addrMxA, addrMxBinv, reMx,
        output addrMxC, weMxC, dataC, busy, done
    );

    modport slave (
        output start, dataA, dataBinv,
        input  addrMxA, addrMxBinv, reMx,
        input  addrMxC, weMxC, dataC, busy, done
    );
endinterface

// File: rtl/mult_axbinv_ctrl_mac.sv
// Signed multiply-accumulate; acc_next is combinational so the
// caller can write the finished dot product on the same edge.
module mac_unit #(
    parameter int DW   = 8,
    parameter int ACCW = 2*DW+2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc_next
);
    logic signed [ACCW-1:0] acc;
    logic signed [2*DW-1:0] p2;
    logic signed [ACCW-1:0] prod;

    always_comb begin
        p2       = a * b;
        prod     = ACCW'(p2);
        acc_next = clear ? prod : acc + prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  acc <= '0;
        else if (en) acc <= acc_next;
    end
endmodule

// File: rtl/mult_axbinv_ctrl.sv
// MxC = MxA * MxBinv sequencer: 64 issue cycles, one-cycle read
// latency, one MxC write per finished dot product.
module mult_axbinv_ctrl
    import mx_pkg::*;
#(
    parameter int DW   = 8,
    parameter int ACCW = 2*DW+2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_axbinv_ctrl_if.master    bus
);
    mx_state_t              st;
    logic [5:0]             n;
    logic [5:0]             n1;
    logic                   vd;
    logic [1:0]             id, jd, kd;
    logic signed [ACCW-1:0] acc_next;

    assign n1 = n + 6'd1;

    mac_unit #(.DW(DW), .ACCW(ACCW)) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (kd == 2'd0),
        .en       (vd),
        .a        (bus.dataA),
        .b        (bus.dataBinv),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= IDLE;
            n              <= '0;
            bus.reMx       <= 1'b0;
            bus.addrMxA    <= '0;
            bus.addrMxBinv <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (st)
                IDLE, DONE: begin
                    st       <= IDLE;
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        st             <= RUN;
                        n              <= '0;
                        bus.reMx       <= 1'b1;
                        bus.addrMxA    <= mx_addr(2'd0, 2'd0);
                        bus.addrMxBinv <= mx_addr(2'd0, 2'd0);
                        bus.busy       <= 1'b1;
                    end
                end
                RUN: begin
                    // n decodes as {i,j,k}; A(i,k) and Binv(k,j)
                    n              <= n1;
                    bus.addrMxA    <= mx_addr(n1[5:4], n1[1:0]);
                    bus.addrMxBinv <= mx_addr(n1[1:0], n1[3:2]);
                    if (n == 6'd63) begin
                        st       <= DRAIN;
                        bus.reMx <= 1'b0;
                    end
                end
                DRAIN: begin
                    n <= n1;
                    if (n[0]) begin
                        st       <= DONE;
                        n        <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vd          <= 1'b0;
            id          <= '0;
            jd          <= '0;
            kd          <= '0;
            bus.weMxC   <= 1'b0;
            bus.dataC   <= '0;
            bus.addrMxC <= '0;
        end else begin
            vd        <= bus.reMx;
            id        <= n[5:4];
            jd        <= n[3:2];
            kd        <= n[1:0];
            bus.weMxC <= vd && (kd == 2'd3);
            if (vd && (kd == 2'd3)) begin
                bus.dataC   <= acc_next;
                bus.addrMxC <= mx_addr(id, jd);
            end
        end
    end
endmodule

// File: tb/tb_mult_axbinv_ctrl.sv
// Scoreboard bench for mult_axbinv_ctrl: expected MxC writes and
// done timing are queued at start, checked as the DUT writes.
module tb_mult_axbinv_ctrl;
    import mx_pkg::*;

    localparam int DW   = 8;
    localparam int ACCW = 2*DW+2;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_axbinv_ctrl_if #(.DW(DW), .ACCW(ACCW)) bus ();

    mult_axbinv_ctrl #(.DW(DW), .ACCW(ACCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic signed [DW-1:0] ma [16];
    logic signed [DW-1:0] mb [16];

    always @(posedge clk)
        if (bus.reMx) begin
            bus.dataA    <= ma[bus.addrMxA];
            bus.dataBinv <= mb[bus.addrMxBinv];
        end

    wr_t qw[$];
    int  qd[$];
    int  cyc = 0;
    int  nchk = 0;
    int  nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tg);
        chk({tg, "_re"},   bus.reMx, 0);
        chk({tg, "_we"},   bus.weMxC, 0);
        chk({tg, "_busy"}, bus.busy, 0);
        chk({tg, "_done"}, bus.done, 0);
        chk({tg, "_aA"},   bus.addrMxA, 0);
        chk({tg, "_aB"},   bus.addrMxBinv, 0);
        chk({tg, "_aC"},   bus.addrMxC, 0);
        chk({tg, "_dC"},   bus.dataC, 0);
    endtask

    task automatic push_run(input int s);
        wr_t w;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                w.data = 0;
                for (int k = 0; k < 4; k++)
                    w.data += int'(ma[4*r+k]) * int'(mb[4*k+c]);
                w.addr = 4*r + c;
                w.cyc  = s + 1 + 4*w.addr + 5;
                qw.push_back(w);
            end
        qd.push_back(s + 67);
    endtask

    always @(negedge clk)
        if (rst_n) begin
            wr_t w;
            if (bus.weMxC) begin
                if (qw.size() == 0) chk("spur_we", bus.weMxC, 0);
                else begin
                    w = qw.pop_front();
                    chk("addrC", bus.addrMxC, w.addr);
                    chk("dataC", $signed(bus.dataC), w.data);
                    chk("we_cyc", cyc, w.cyc);
                end
            end
            if (bus.done) begin
                if (qd.size() == 0) chk("spur_done", bus.done, 0);
                else begin
                    chk("done_cyc", cyc, qd.pop_front());
                    chk("busy_done", bus.busy, 0);
                end
            end
        end

    task automatic go();
        @(negedge clk);
        bus.start = 1'b1;
        push_run(cyc);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_t0", bus.busy, 1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (qw.size() == 0 && qd.size() == 0) break;
        end
        chk("drain_q", qw.size() + qd.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pat_ident();
        for (int a = 0; a < 16; a++) begin
            ma[a] = DW'(a);
            mb[a] = (a[1:0] == a[3:2]) ? DW'(1) : DW'(0);
        end
    endtask

    task automatic pat_neg();
        for (int a = 0; a < 16; a++) begin
            ma[a] = -8'sd128;
            mb[a] = -8'sd128;
        end
    endtask

    task automatic pat_ramp();
        for (int a = 0; a < 16; a++) begin
            ma[a] = DW'(1);
            mb[a] = DW'(int'(a[1:0]) - 1);
        end
    endtask

    initial begin
        int s;
        bus.start = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        pat_ident();
        go();
        wait_empty();

        pat_neg();
        go();
        wait_empty();

        pat_ramp();
        go();
        wait_empty();

        pat_ident();
        go();
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty();

        pat_neg();
        go();
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("mid_rst");
        qw.delete();
        qd.delete();
        repeat (2) begin
            @(negedge clk);
            chk_zero("hold_rst");
        end
        rst_n = 1'b1;
        pat_ramp();
        go();
        wait_empty();

        pat_ident();
        go();
        s = cyc - 1;
        while (cyc < s + 61) @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 20 && cyc < s + 67; i++) @(negedge clk);
        chk("restart_at", cyc, s + 67);
        pat_ramp();
        push_run(cyc);
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_busy", bus.busy, 1);
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
